// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   ctrl_state_e : sequencer states
//   reg_tag_t    : one in-flight register write {valid, dest, is_load}
//   fwd_sel_e    : bypass source selection (register file / mem / wb)
//   pick_fwd     : youngest-match bypass select from a per-tag hit vector
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    // Tag slots, youngest first.
    localparam int NUM_TAGS = 3;
    localparam int TAG_EX   = 0;
    localparam int TAG_MEM  = 1;
    localparam int TAG_WB   = 2;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // DRAIN lasts at least DRAIN_LAST+1 unfrozen cycles: the halt itself
    // has to walk through EX, MEM and WB.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } reg_tag_t;

    localparam reg_tag_t TAG_NONE = '{valid: 1'b0, dest: '0, is_load: 1'b0};

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // The mem tag is younger than wb, so it wins when both match.
    function automatic fwd_sel_e pick_fwd(input logic [NUM_TAGS-1:0] hit);
        if (hit[TAG_MEM]) return FWD_MEM;
        if (hit[TAG_WB])  return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// hazard_match: compares one source operand against the ex/mem/wb tags.
//   src, src_used : operand register number and its "read from RF" bit
//   tags          : the three in-flight write tags (index 0 = ex)
//   hit           : per-tag match (valid, nonzero dest, dest == src, used)
//   ld_hit        : hit qualified by the tag being a load
module hazard_match
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0]          src,
    input  logic                      src_used,
    input  reg_tag_t [NUM_TAGS-1:0]   tags,
    output logic [NUM_TAGS-1:0]       hit,
    output logic [NUM_TAGS-1:0]       ld_hit
);

    always_comb begin
        hit    = '0;
        ld_hit = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            // $0 is hardwired, so a write to it never creates a dependency.
            hit[i]    = src_used && tags[i].valid &&
                        (tags[i].dest != REG_ZERO) && (tags[i].dest == src);
            ld_hit[i] = hit[i] && tags[i].is_load;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central sequencer for the 5-stage MIPS pipeline.
// Keeps a three-deep scoreboard of in-flight register writes (ex/mem/wb),
// raises per-operand RAW hazards to decode, and drives stall / bubble /
// flush / freeze controls. Cache misses freeze the pipe; a halt drains it
// and then parks in HALTED until reset.
//
// Ports:
//   clk, rst_b                 clock, asynchronous active-low reset
//   id_valid, id_rs, id_rt,    decode-stage instruction: sources, source
//   id_rs_used, id_rt_used,    used bits, destination, write/load/halt
//   id_dest, id_reg_write,     flags
//   id_mem_to_reg, id_halt
//   ex_redirect                taken branch / jump resolved in EX
//   mem_busy                   data cache miss in progress
//   has_reg1/2_hazard          per-operand RAW hazard (combinational)
//   stall_if, stall_id,        pipeline controls
//   bubble_ex, flush_if_id,
//   freeze_all
//   fwd_a_sel, fwd_b_sel       bypass selects (forwarding build only)
//   halted                     sticky, pipeline drained after a halt
//
// Build option: PIPELINE_HAZARD_CTRL_FORWARDING_EN adds the EX/MEM bypass:
// only a load sitting in the ex tag stalls, and fwd_*_sel are exported.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W       = REG_W,   // must equal the tag dest width
    parameter bit RF_WRITE_THROUGH = 1'b1
)(
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_halt,
    input  logic                  ex_redirect,
    input  logic                  mem_busy,
    output logic                  has_reg1_hazard,
    output logic                  has_reg2_hazard,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_if_id,
    output logic                  freeze_all,
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
`endif
    output logic                  halted
);

    localparam int NUM_OPS = 2;   // index 0 = rs, 1 = rt

    ctrl_state_e             state_q, state_d;
    reg_tag_t [NUM_TAGS-1:0] tag_q, tag_d;
    logic                    flush_pend_q, flush_pend_d;
    logic [1:0]              drain_cnt_q, drain_cnt_d;

    logic [NUM_OPS-1:0][REG_ADDR_W-1:0] op_reg;
    logic [NUM_OPS-1:0]                 op_used;
    logic [NUM_OPS-1:0][NUM_TAGS-1:0]   op_hit;
    logic [NUM_OPS-1:0][NUM_TAGS-1:0]   op_ld_hit;
    logic [NUM_OPS-1:0]                 op_hz;
    logic                               hz;
    logic                               unused_ld;

    assign op_reg  = {id_rt, id_rs};
    assign op_used = {id_rt_used, id_rt_used ? id_rs_used : id_rs_used};

    generate
        for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
            hazard_match u_match (
                .src      (op_reg[g]),
                .src_used (op_used[g]),
                .tags     (tag_q),
                .hit      (op_hit[g]),
                .ld_hit   (op_ld_hit[g])
            );
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
            // ALU results are bypassed; only a load still in EX is too late.
            assign op_hz[g] = id_valid && op_ld_hit[g][TAG_EX];
`else
            // With a write-through RF the WB write lands before the read.
            assign op_hz[g] = id_valid &&
                              (op_hit[g][TAG_EX] || op_hit[g][TAG_MEM] ||
                               (!RF_WRITE_THROUGH && op_hit[g][TAG_WB]));
`endif
        end
    endgenerate

    assign unused_ld       = ^op_ld_hit;
    assign has_reg1_hazard = op_hz[0];
    assign has_reg2_hazard = op_hz[1];
    assign hz              = |op_hz;

`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
    assign fwd_a_sel = pick_fwd(op_hit[0]);
    assign fwd_b_sel = pick_fwd(op_hit[1]);
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= ST_RUN;
            tag_q        <= {NUM_TAGS{TAG_NONE}};
            flush_pend_q <= 1'b0;
            drain_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            flush_pend_q <= flush_pend_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    always_comb begin
        logic     redirect;
        reg_tag_t new_tag;

        state_d      = state_q;
        tag_d        = tag_q;
        flush_pend_d = flush_pend_q;
        drain_cnt_d  = drain_cnt_q;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        bubble_ex    = 1'b0;
        flush_if_id  = 1'b0;
        freeze_all   = 1'b0;
        halted       = 1'b0;
        redirect     = ex_redirect || flush_pend_q;
        new_tag      = TAG_NONE;

        case (state_q)
            // MEM_WAIT only differs from RUN by remembering the wait; the
            // first cycle with mem_busy low is already a normal run cycle
            // and applies any redirect that arrived during the freeze.
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_busy) begin
                    state_d      = ST_MEM_WAIT;
                    freeze_all   = 1'b1;
                    stall_if     = 1'b1;
                    stall_id     = 1'b1;
                    flush_pend_d = redirect;
                end else begin
                    state_d      = ST_RUN;
                    flush_pend_d = 1'b0;
                    if (redirect) begin
                        flush_if_id = 1'b1;
                        bubble_ex   = 1'b1;
                    end else if (hz) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else begin
                        if (id_valid && id_reg_write) begin
                            new_tag.valid   = 1'b1;
                            new_tag.dest    = id_dest;
                            new_tag.is_load = id_mem_to_reg;
                        end
                        if (id_valid && id_halt) begin
                            state_d     = ST_DRAIN;
                            drain_cnt_d = '0;
                        end
                    end
                    tag_d = {tag_q[TAG_MEM], tag_q[TAG_EX], new_tag};
                end
            end

            ST_DRAIN: begin
                stall_if = 1'b1;
                if (mem_busy) begin
                    freeze_all = 1'b1;
                    stall_id   = 1'b1;
                end else begin
                    bubble_ex = 1'b1;
                    tag_d     = {tag_q[TAG_MEM], tag_q[TAG_EX], TAG_NONE};
                    if (drain_cnt_q != DRAIN_LAST) begin
                        drain_cnt_d = drain_cnt_q + 2'd1;
                    end else if (!(tag_q[TAG_EX].valid || tag_q[TAG_MEM].valid ||
                                   tag_q[TAG_WB].valid)) begin
                        state_d = ST_HALTED;
                    end
                end
            end

            ST_HALTED: begin
                halted   = 1'b1;
                stall_if = 1'b1;
                stall_id = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. The reference model tracks
// every issued register write by the pipeline cycle it issued in; its age
// (unfrozen cycles since issue) says where it sits: 1 = ex, 2 = mem, 3 = wb.
module tb_pipeline_hazard_ctrl;

    localparam bit RF_WT = 1'b1;
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_b;
    logic       id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_to_reg, id_halt;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       ex_redirect, mem_busy;
    logic       has_reg1_hazard, has_reg2_hazard, stall_if, stall_id;
    logic       bubble_ex, flush_if_id, freeze_all, halted;
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
    logic [1:0] fwd_a_sel, fwd_b_sel;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .RF_WRITE_THROUGH(RF_WT)) dut (
        .clk(clk), .rst_b(rst_b),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_halt(id_halt),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .has_reg1_hazard(has_reg1_hazard), .has_reg2_hazard(has_reg2_hazard),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .freeze_all(freeze_all),
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`endif
        .halted(halted)
    );

    task automatic cmp(input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [4:0] dest; bit ld; int t; } wr_t;
    wr_t wq[$];
    int  ptime  = 0;   // advances only on unfrozen cycles
    bit  m_pend = 0, m_drain = 0, m_halt = 0;
    int  m_dcnt = 0;

    function automatic bit m_hz(input logic [4:0] r, input logic used);
        bit h = 0;
        if (!used || r == 5'd0) return 0;
        foreach (wq[i]) begin
            int age = ptime - wq[i].t;
            if (wq[i].dest == r) begin
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
                if (age == 1 && wq[i].ld) h = 1;
`else
                if (age >= 1 && age <= (RF_WT ? 2 : 3)) h = 1;
`endif
            end
        end
        return h;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r, input logic used);
        bit h2 = 0, h3 = 0;
        if (!used || r == 5'd0) return 2'd0;
        foreach (wq[i]) begin
            int age = ptime - wq[i].t;
            if (wq[i].dest == r && age == 2) h2 = 1;
            if (wq[i].dest == r && age == 3) h3 = 1;
        end
        return h2 ? 2'd1 : (h3 ? 2'd2 : 2'd0);
    endfunction

    function automatic bit m_empty();
        foreach (wq[i]) if (ptime - wq[i].t <= 3) return 0;
        return 1;
    endfunction

    always @(negedge clk) begin
        logic e_h1, e_h2, e_sif, e_sid, e_bub, e_fl, e_frz, e_hlt, redir;
        logic [1:0] e_fa, e_fb;
        e_sif = 0; e_sid = 0; e_bub = 0; e_fl = 0; e_frz = 0; e_hlt = 0;
        if (!rst_b) begin
            wq.delete(); ptime = 0; m_pend = 0; m_drain = 0; m_halt = 0; m_dcnt = 0;
        end
        e_h1 = id_valid && m_hz(id_rs, id_rs_used);
        e_h2 = id_valid && m_hz(id_rt, id_rt_used);
        e_fa = m_fwd(id_rs, id_rs_used);
        e_fb = m_fwd(id_rt, id_rt_used);
        if (!rst_b) begin
            // everything idle
        end else if (m_halt) begin
            e_hlt = 1; e_sif = 1; e_sid = 1;
        end else if (mem_busy) begin
            e_frz = 1; e_sif = 1; e_sid = 1;
            if (!m_drain) m_pend = m_pend || ex_redirect;
        end else if (m_drain) begin
            e_sif = 1; e_bub = 1;
            if (m_dcnt >= 2 && m_empty()) m_halt = 1;
            m_dcnt++;
            ptime++;
        end else begin
            redir = ex_redirect || m_pend;
            m_pend = 0;
            if (redir) begin
                e_fl = 1; e_bub = 1;
            end else if (e_h1 || e_h2) begin
                e_sif = 1; e_sid = 1; e_bub = 1;
            end else begin
                if (id_valid && id_reg_write) wq.push_back('{id_dest, id_mem_to_reg, ptime});
                if (id_valid && id_halt) begin m_drain = 1; m_dcnt = 0; end
            end
            ptime++;
        end
        while (wq.size() > 0 && ptime - wq[0].t > 3) void'(wq.pop_front());

        cmp("has_reg1_hazard", has_reg1_hazard, e_h1);
        cmp("has_reg2_hazard", has_reg2_hazard, e_h2);
        cmp("stall_if", stall_if, e_sif);
        cmp("stall_id", stall_id, e_sid);
        cmp("bubble_ex", bubble_ex, e_bub);
        cmp("flush_if_id", flush_if_id, e_fl);
        cmp("freeze_all", freeze_all, e_frz);
        cmp("halted", halted, e_hlt);
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
        cmp("fwd_a_sel", fwd_a_sel, e_fa);
        cmp("fwd_b_sel", fwd_b_sel, e_fb);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_id(input bit v, input logic [4:0] rs, input bit ru,
                          input logic [4:0] rt, input bit tu, input logic [4:0] dest,
                          input bit rw, input bit ld, input bit hlt);
        id_valid = v; id_rs = rs; id_rs_used = ru; id_rt = rt; id_rt_used = tu;
        id_dest = dest; id_reg_write = rw; id_mem_to_reg = ld; id_halt = hlt;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        idle();
        repeat (n) nxt();
    endtask

    task automatic do_reset();
        idle(); ex_redirect = 0; mem_busy = 0; rst_b = 0;
        mid(); nxt(); rst_b = 1;
    endtask

    // add $3,$1,$2 ; sub $4,$3,$5 back to back
    task automatic dep_pair(input string tag);
        set_id(1, 1, 1, 2, 1, 3, 1, 0, 0);
        mid(); cmp({tag, "_a_h1"}, has_reg1_hazard, 0); nxt();
        set_id(1, 3, 1, 5, 1, 4, 1, 0, 0);
        mid(); cmp({tag, "_b_h1"}, has_reg1_hazard, FWD ? 0 : 1);
               cmp({tag, "_b_h2"}, has_reg2_hazard, 0);
               cmp({tag, "_b_bubble"}, bubble_ex, FWD ? 0 : 1); nxt();
        mid(); cmp({tag, "_c_h1"}, has_reg1_hazard, FWD ? 0 : 1);
               cmp({tag, "_c_bubble"}, bubble_ex, FWD ? 0 : 1); nxt();
        mid(); cmp({tag, "_d_h1"}, has_reg1_hazard, 0);
               cmp({tag, "_d_stall_if"}, stall_if, 0); nxt();
        settle(3);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_b = 0; idle(); ex_redirect = 0; mem_busy = 0;
        repeat (2) mid();
        cmp("rst_stall_if", stall_if, 0);
        cmp("rst_bubble", bubble_ex, 0);
        cmp("rst_halted", halted, 0);
        nxt(); rst_b = 1;

        dep_pair("cold");

        // producer writes $0, consumer reads $0
        set_id(1, 1, 1, 2, 1, 0, 1, 0, 0); mid(); nxt();
        set_id(1, 0, 1, 0, 1, 13, 1, 0, 0);
        mid(); cmp("zero_h1", has_reg1_hazard, 0); cmp("zero_h2", has_reg2_hazard, 0);
               cmp("zero_stall", stall_if, 0); nxt();
        settle(3);

        // lw $2 ; add $6,$2,$2
        set_id(1, 1, 1, 0, 0, 2, 1, 1, 0); mid(); nxt();
        set_id(1, 2, 1, 2, 1, 6, 1, 0, 0);
        mid(); cmp("lu1_h1", has_reg1_hazard, 1); cmp("lu1_h2", has_reg2_hazard, 1); nxt();
        mid(); cmp("lu2_h1", has_reg1_hazard, FWD ? 0 : 1);
`ifdef PIPELINE_HAZARD_CTRL_FORWARDING_EN
               cmp("lu2_fwd_a", fwd_a_sel, 1); cmp("lu2_fwd_b", fwd_b_sel, 1);
`endif
               nxt();
        if (!FWD) begin
            mid(); cmp("lu3_h1", has_reg1_hazard, 0); cmp("lu3_bubble", bubble_ex, 0); nxt();
        end
        settle(3);

        // redirect beats a hazard in the same cycle
        set_id(1, 1, 1, 0, 0, 10, 1, 0, 0); mid(); nxt();
        set_id(1, 10, 1, 0, 0, 14, 1, 0, 0); ex_redirect = 1;
        mid(); cmp("rdh_flush", flush_if_id, 1); cmp("rdh_bubble", bubble_ex, 1);
               cmp("rdh_stall_if", stall_if, 0); cmp("rdh_h1", has_reg1_hazard, FWD ? 0 : 1); nxt();
        ex_redirect = 0;
        settle(3);

        // mem_busy 4 cycles, redirect in the first of them
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 0); mem_busy = 1; ex_redirect = 1;
        mid(); cmp("mw1_freeze", freeze_all, 1); cmp("mw1_flush", flush_if_id, 0); nxt();
        ex_redirect = 0;
        for (int i = 2; i <= 4; i++) begin
            mid(); cmp("mw_freeze", freeze_all, 1); cmp("mw_flush", flush_if_id, 0); nxt();
        end
        mem_busy = 0;
        mid(); cmp("mw5_freeze", freeze_all, 0); cmp("mw5_flush", flush_if_id, 1); nxt();
        set_id(1, 7, 1, 0, 0, 0, 0, 0, 0);   // squashed $7 writer left no tag
        mid(); cmp("mw6_flush", flush_if_id, 0); cmp("mw6_h1", has_reg1_hazard, 0); nxt();
        settle(3);

        // halt with two producers in flight
        set_id(1, 1, 1, 0, 0, 8, 1, 0, 0); mid(); nxt();
        set_id(1, 2, 1, 0, 0, 9, 1, 0, 0); mid(); nxt();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
        mid(); cmp("hlt_issue_stall", stall_if, 0); nxt();
        idle();
        for (int i = 0; i < 3; i++) begin
            mid(); cmp("drain_stall_if", stall_if, 1); cmp("drain_bubble", bubble_ex, 1);
                   cmp("drain_halted", halted, 0); nxt();
        end
        for (int i = 0; i < 10; i++) begin
            mid(); cmp("hlt_halted", halted, 1); cmp("hlt_stall_if", stall_if, 1); nxt();
        end

        // reset in the middle of DRAIN with valid tags
        do_reset();
        set_id(1, 1, 1, 0, 0, 11, 1, 0, 0); mid(); nxt();
        set_id(1, 2, 1, 0, 0, 12, 1, 0, 0); mid(); nxt();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1); mid(); nxt();
        idle();
        mid(); cmp("rd_drain_stall_if", stall_if, 1); nxt();
        rst_b = 0;
        #1;
        cmp("rd_stall_if", stall_if, 0); cmp("rd_bubble", bubble_ex, 0);
        cmp("rd_stall_id", stall_id, 0); cmp("rd_halted", halted, 0);
        mid(); nxt(); rst_b = 1;
        dep_pair("warm");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline.
- Tracks in-flight register writes in EX/MEM/WB with a tag scoreboard.
- Raises per-operand RAW hazards to the decode stage and generates stall, bubble and flush controls for IF/ID/EX.
- Freezes the pipe on cache misses and drains it on a halt instruction before asserting the final halted flag.

Parameters:
- REG_ADDR_W, 5: register-number width.
- RF_WRITE_THROUGH, 1: 1 = the register file writes before it reads in the same cycle, so the WB tag never causes a hazard; 0 = the WB tag is checked too.

Ports:
- clk  in  1  clock.
- rst_b  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs / id_rt  in  5  source register numbers.
- id_rs_used / id_rt_used  in  1  the operand is read from the register file (is_reg1_valid / is_reg2_valid).
- id_dest  in  5  destination register number.
- id_reg_write  in  1  the instruction writes id_dest.
- id_mem_to_reg  in  1  the instruction is a load.
- id_halt  in  1  decode holds a halt.
- ex_redirect  in  1  branch taken, jump or jr resolved this cycle.
- mem_busy  in  1  data cache miss in progress.
- has_reg1_hazard / has_reg2_hazard  out  1  per-operand RAW hazard.
- stall_if  out  1  hold PC and IF/ID.
- stall_id  out  1  hold the ID/EX input.
- bubble_ex  out  1  inject a NOP into ID/EX.
- flush_if_id  out  1  squash IF/ID.
- freeze_all  out  1  hold every pipeline register.
- halted  out  1  sticky: pipeline drained after a halt.

Behaviour:
- State: FSM {RUN, MEM_WAIT, DRAIN, HALTED}, plus three tags ex/mem/wb, each {valid, dest, is_load}.
- Reset: all tags cleared, state RUN. All outputs then read 0. Reset mid-operation discards every tag and any latched flush.
- Hazard match: a tag matches an operand when the tag is valid, its dest is nonzero, dest equals the operand, and the operand's _used bit is set.
  - Register $0 never produces a hazard.
  - has_regN_hazard = match against ex, mem, or wb (wb only when RF_WRITE_THROUGH=0), gated by id_valid.
- Stall condition: hz = has_reg1_hazard OR has_reg2_hazard.
  - In RUN with hz and no redirect: stall_if = stall_id = bubble_ex = 1.
- Tag advance (every cycle unless frozen): wb <= mem, mem <= ex.
  - ex <= {1, id_dest, id_mem_to_reg} if id_valid & id_reg_write & !hz & !redirect; otherwise ex is invalid.
- Redirect: ex_redirect asserts flush_if_id for exactly that cycle.
  - The ID instruction is squashed: it enters no tag and bubble_ex = 1.
  - Redirect beats hazard and halt in the same cycle.
- RUN -> MEM_WAIT when mem_busy = 1.
  - While in MEM_WAIT: freeze_all = stall_if = stall_id = 1 and tags hold.
  - A redirect arriving with mem_busy is latched and flush_if_id is issued on the first RUN cycle after exit.
  - MEM_WAIT -> RUN on the first cycle mem_busy = 0.
- RUN -> DRAIN when id_valid & id_halt & !hz & !redirect.
  - In DRAIN: stall_if = 1 and bubble_ex = 1 every cycle; tags keep advancing; a mem_busy stall is still honoured.
  - DRAIN -> HALTED when all three tags are invalid and mem_busy = 0; minimum 3 cycles.
- HALTED: halted = 1, stall_if = stall_id = 1, absorbing until reset.
- Latency: hazard outputs are combinational from the ID inputs and the current tags, so no added cycle. A dependent instruction stalls until the producer leaves the last checked tag.

Optional Feature:
- Macro: PIPELINE_HAZARD_CTRL_FORWARDING_EN.
- Defined: the EX/MEM bypass network is present.
  - Only a load in the ex tag (is_load = 1) raises a hazard: a 1-cycle load-use stall.
  - mem and wb matches never stall.
  - Extra outputs fwd_a_sel / fwd_b_sel (2 bits each: 0 = register file, 1 = mem, 2 = wb) select the youngest matching tag.
- Undefined: full scoreboard stalling as described above; no fwd ports.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - typedef ctrl_state_e (the FSM states);
  - struct reg_tag_t {valid, dest, is_load};
  - REG_ZERO constant;
  - fwd_sel_e enum.
- One sub-module, hazard_match: combinational compare of one operand against three tags, instantiated twice (rs, rt).

Test Plan:
- add $3 then sub $4,$3,$5 back-to-back (no forwarding, RF_WRITE_THROUGH = 1) -> has_reg1_hazard high for 2 cycles, bubble_ex 2 cycles; sub issues on cycle 3.
- lw $2 then add $6,$2,$2 with FORWARDING_EN -> both hazards high for 1 cycle, then fwd_a_sel = fwd_b_sel = 1 on the issue cycle.
- Producer writes $0, consumer reads $0 -> no hazard and no stall.
- mem_busy held 4 cycles while ex_redirect pulses in cycle 1 -> freeze_all high 4 cycles; flush_if_id pulses once, on the first cycle after mem_busy falls.
- Halt with 2 producers in flight -> DRAIN, halted rises 3 cycles later and stays high; stall_if stays 1 across 10 extra cycles.
- rst_b asserted during DRAIN with valid tags -> all outputs 0 immediately; the next dependent pair behaves as from cold reset.
